// File: rtl/baud_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : baud_sched_pkg
// Purpose  : Shared state encoding and rate constants for the baud scheduler.
// Revision : 1.0
// ============================================================================
package baud_sched_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PEND    = 2'd2,
        LOAD    = 2'd3
    } state_e;

    localparam int OS_RATE      = 16;
    localparam int OS_W         = $clog2(OS_RATE);
    localparam int PEND_TIMEOUT = 65535;

endpackage
`default_nettype wire

// File: rtl/baud_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : baud_sched_ctrl_if
// Purpose  : Divisor handshake, engine busy flags and baud tick outputs.
// Revision : 1.0
// ============================================================================
interface baud_sched_ctrl_if #(
    parameter int BITS = 10
);
    logic            run;
    logic            cfg_valid;
    logic [BITS-1:0] cfg_div;
    logic            cfg_ready;
    logic            tx_busy;
    logic            rx_busy;
    logic            tick;
    logic            bit_tick;
    logic [BITS-1:0] div_active;
    logic            cfg_forced;

    modport master (
        output run, cfg_valid, cfg_div, tx_busy, rx_busy,
        input  cfg_ready, tick, bit_tick, div_active, cfg_forced
    );

    modport slave (
        input  run, cfg_valid, cfg_div, tx_busy, rx_busy,
        output cfg_ready, tick, bit_tick, div_active, cfg_forced
    );
endinterface
`default_nettype wire

// File: rtl/baud_div_counter.sv
`default_nettype none
// ============================================================================
// Module   : baud_div_counter
// Purpose  : Wrapping up-counter; done flags count == final value.
// Revision : 1.0
// ============================================================================
module baud_div_counter #(
    parameter int BITS = 10
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            en,
    input  wire logic            clr,
    input  wire logic [BITS-1:0] final_val,
    output logic                 done
);
    logic [BITS-1:0] count_q, count_d;

    assign done = (count_q == final_val);

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = done ? '0 : count_q + BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule
`default_nettype wire

// File: rtl/baud_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : baud_sched_ctrl
// Purpose  : Baud divisor owner; defers divisor changes until TX/RX are idle.
//            Optional PEND watchdog enabled by BAUD_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module baud_sched_ctrl
    import baud_sched_pkg::*;
#(
    parameter int BITS        = 10,
    parameter int DEFAULT_DIV = 650
) (
    input  wire logic          clk,
    input  wire logic          reset,
    baud_sched_ctrl_if.slave   bus
);
    state_e          state_q, state_d;
    logic [BITS-1:0] div_active_q, div_active_d;
    logic [BITS-1:0] pend_div_q, pend_div_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            counting, cnt_en, cnt_done, hs, idle, timeout, tick_w;

    assign counting      = (state_q == RUN) || (state_q == PEND);
    assign bus.cfg_ready = (state_q == STOPPED) || (state_q == RUN);
    assign hs            = bus.cfg_valid && bus.cfg_ready;
    assign idle          = !bus.tx_busy && !bus.rx_busy;

    // div_active takes the new value on entry to LOAD so it is visible
    // during the LOAD cycle itself.
    always_comb begin
        state_d      = state_q;
        div_active_d = div_active_q;
        pend_div_d   = pend_div_q;
        case (state_q)
            STOPPED: begin
                if (hs) begin
                    pend_div_d   = bus.cfg_div;
                    div_active_d = bus.cfg_div;
                    state_d      = LOAD;
                end else if (bus.run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    pend_div_d = bus.cfg_div;
                    state_d    = PEND;
                end else if (!bus.run) begin
                    state_d = STOPPED;
                end
            end
            PEND: begin
                if (idle || !bus.run || timeout) begin
                    div_active_d = pend_div_q;
                    state_d      = LOAD;
                end
            end
            LOAD:    state_d = bus.run ? RUN : STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    // Counters only advance while staying in a counting state.
    assign cnt_en = counting && ((state_d == RUN) || (state_d == PEND));
    assign tick_w = counting && cnt_done;

    baud_div_counter #(.BITS(BITS)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (cnt_en),
        .clr       (!cnt_en),
        .final_val (div_active_q),
        .done      (cnt_done)
    );

    always_comb begin
        os_cnt_d = os_cnt_q;
        if (!cnt_en)
            os_cnt_d = '0;
        else if (tick_w)
            os_cnt_d = os_cnt_q + OS_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= STOPPED;
            div_active_q <= BITS'(DEFAULT_DIV);
            pend_div_q   <= '0;
            os_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            pend_div_q   <= pend_div_d;
            os_cnt_q     <= os_cnt_d;
        end
    end

    assign bus.tick       = tick_w;
    assign bus.bit_tick   = tick_w && (os_cnt_q == OS_W'(OS_RATE - 1));
    assign bus.div_active = div_active_q;

`ifdef BAUD_SCHED_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        forced_q, forced_d;

    assign timeout  = (state_q == PEND) && (wd_q == 16'(PEND_TIMEOUT - 1));
    assign wd_d     = (state_q == PEND) ? wd_q + 16'd1 : 16'd0;
    assign forced_d = timeout && !idle && bus.run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q     <= '0;
            forced_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            forced_q <= forced_d;
        end
    end

    assign bus.cfg_forced = forced_q;
`else
    assign timeout        = 1'b0;
    assign bus.cfg_forced = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_baud_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_sched_ctrl
// Purpose  : Directed bench with a cycle-level reference model of the ticks.
// Revision : 1.0
// ============================================================================
module tb_baud_sched_ctrl;
    localparam int BITS = 10;
    localparam int DDIV = 650;
`ifdef BAUD_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    baud_sched_ctrl_if #(.BITS(BITS)) bus ();

    baud_sched_ctrl #(.BITS(BITS), .DEFAULT_DIV(DDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 stopped, 1 counting, 2 counting with update waiting,
    // 3 loading. Ticks derive from cycles elapsed since counting began.
    int m_phase = 0, m_div = DDIV, m_pend = 0, m_elapsed = 0, m_wd = 0;
    bit m_forced = 1'b0;

    task automatic model_step();
        bit hs, idle, to, nf;
        if (reset) begin
            m_phase = 0; m_div = DDIV; m_pend = 0;
            m_elapsed = 0; m_wd = 0; m_forced = 1'b0;
        end else begin
            hs   = bus.cfg_valid && (m_phase <= 1);
            idle = !bus.tx_busy && !bus.rx_busy;
            nf   = 1'b0;
            case (m_phase)
                0: if (hs) begin m_div = int'(bus.cfg_div); m_phase = 3; end
                   else if (bus.run) begin m_phase = 1; m_elapsed = 0; end
                1: if (hs) begin m_pend = int'(bus.cfg_div); m_phase = 2; m_wd = 0; m_elapsed++; end
                   else if (!bus.run) m_phase = 0;
                   else m_elapsed++;
                2: begin
                    to = TIMEOUT_ON && (m_wd == 65534);
                    if (idle || !bus.run || to) begin
                        m_div = m_pend; m_phase = 3; nf = to && !idle && bus.run;
                    end else begin
                        m_elapsed++; m_wd++;
                    end
                end
                default: begin m_phase = bus.run ? 1 : 0; m_elapsed = 0; end
            endcase
            m_forced = nf;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            bit cnt_on;
            int per;
            cnt_on = (m_phase == 1) || (m_phase == 2);
            per    = m_div + 1;
            check("m_tick",  int'(bus.tick),
                  int'(cnt_on && (m_elapsed % per == m_div)));
            check("m_bit",   int'(bus.bit_tick),
                  int'(cnt_on && (m_elapsed % (16 * per) == 16 * per - 1)));
            check("m_ready", int'(bus.cfg_ready), int'(m_phase <= 1));
            check("m_div",   int'(bus.div_active), m_div);
            check("m_forced", int'(bus.cfg_forced), int'(m_forced));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input int bound, output int n);
        bit hit;
        n = 0; hit = 1'b0;
        while (!hit && n < bound) begin
            step();
            n++;
            case (which)
                0:       hit = bus.tick;
                1:       hit = bus.bit_tick;
                default: hit = bus.cfg_forced;
            endcase
        end
        if (!hit) begin
            checks++; failures++;
            $display("FAIL wait_sig%0d: no pulse within %0d cycles", which, bound);
            n = -1;
        end
    endtask

    // One-cycle handshake; the offered value is scrambled afterwards.
    task automatic offer(input int d);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = BITS'(d);
        step();
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = BITS'($urandom_range(0, 1023));
    endtask

    initial begin
        int n;
        bit saw;
        bus.run = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
        bus.tx_busy = 1'b0; bus.rx_busy = 1'b0;
        step(); step();
        check("rst_div",    int'(bus.div_active), DDIV);
        check("rst_ready",  int'(bus.cfg_ready), 1);
        check("rst_tick",   int'(bus.tick), 0);
        check("rst_bit",    int'(bus.bit_tick), 0);
        check("rst_forced", int'(bus.cfg_forced), 0);
        reset = 1'b0;
        step();

        // Default divisor start-up.
        bus.run = 1'b1;
        wait_sig(0, 2000, n);  check("first_tick", n, 651);
        wait_sig(0, 2000, n);  check("tick_period", n, 651);
        wait_sig(1, 12000, n); check("first_bit", n, 10416 - 1302);

        // Update while stopped.
        bus.run = 1'b0;
        step(); step();
        check("stop_ready", int'(bus.cfg_ready), 1);
        offer(3);
        check("stop_load_div", int'(bus.div_active), 3);
        step();
        bus.run = 1'b1;
        wait_sig(0, 50, n); check("div3_first", n, 4);
        wait_sig(0, 50, n); check("div3_period", n, 4);

        // Deferred update while transmitter busy.
        bus.tx_busy = 1'b1;
        offer(7);
        check("pend_ready", int'(bus.cfg_ready), 0);
        check("pend_old_div", int'(bus.div_active), 3);
        wait_sig(0, 50, n);
        wait_sig(0, 50, n); check("pend_period", n, 4);
        bus.tx_busy = 1'b0;
        wait_sig(0, 50, n); check("div7_first", n, 9);
        check("div7_active", int'(bus.div_active), 7);
        wait_sig(0, 50, n); check("div7_period", n, 8);

        // Zero divisor.
        offer(0);
        wait_sig(0, 50, n); check("div0_first", n, 2);
        wait_sig(1, 50, n); check("div0_bit_first", n, 15);
        wait_sig(1, 50, n); check("div0_bit_period", n, 16);

        // run drops while receiver holds the update off.
        bus.rx_busy = 1'b1;
        offer(5);
        step(); step(); step();
        bus.run = 1'b0;
        step();
        check("runfall_load_tick", int'(bus.tick), 0);
        check("runfall_load_div", int'(bus.div_active), 5);
        check("runfall_load_ready", int'(bus.cfg_ready), 0);
        step();
        check("runfall_stop_ready", int'(bus.cfg_ready), 1);
        check("runfall_stop_tick", int'(bus.tick), 0);
        bus.rx_busy = 1'b0;

        // Stuck transmitter.
        bus.run = 1'b1;
        repeat (5) step();
        bus.tx_busy = 1'b1;
        offer(2);
`ifdef BAUD_SCHED_TIMEOUT_EN
        wait_sig(2, 70000, n); check("timeout_cycles", n, 65535);
        check("timeout_div", int'(bus.div_active), 2);
        step();
        check("timeout_pulse_once", int'(bus.cfg_forced), 0);
`else
        saw = 1'b0;
        repeat (3000) begin
            step();
            if (bus.cfg_forced) saw = 1'b1;
        end
        check("no_forced", int'(saw), 0);
        check("still_pend", int'(bus.cfg_ready), 0);
        check("still_old_div", int'(bus.div_active), 5);
`endif

        // Asynchronous reset mid-operation discards the pending update.
        reset = 1'b1;
        #1;
        check("arst_div", int'(bus.div_active), DDIV);
        check("arst_ready", int'(bus.cfg_ready), 1);
        check("arst_tick", int'(bus.tick), 0);
        bus.tx_busy = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        check("post_rst_div", int'(bus.div_active), DDIV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
